// File: rtl/zle_enc_param.sv
// Parametrised zero run-length encoder: literals pass through, zero runs collapse to run tokens.
// Optional macro ZLE_SINGLE_ZERO_LITERAL_EN emits a terminated run of one zero as literal 0.
module zle_enc_param #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_eos,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W:0]   out_data,
    output logic         out_eos,
    output logic         out_valid,
    input  logic         out_ready
);

    // Handshake: a token moves on a channel in a cycle where valid && ready at the clock edge;
    // the producer holds valid/data until then, and ready never looks at valid.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ZEROS    = 2'd1,
        PEND_LIT = 2'd2,
        PEND_EOS = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_RUN = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     hold;
    logic             slot_free;
    logic             accept;
    logic             in_zero;

    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && (state == IDLE || state == ZEROS);
        accept    = in_valid && in_ready;
        in_zero   = (in_data == '0);
    end

    function automatic logic [W:0] run_tok(input logic [CNT_W-1:0] len);
        logic [W:0] t;
        t             = '0;
        t[W]          = 1'b1;
        t[CNT_W-1:0]  = len;
        return t;
    endfunction

    // A run closed by a nonzero word or eos; a run closed by MAX_RUN always uses run_tok.
    function automatic logic [W:0] term_tok(input logic [CNT_W-1:0] len);
`ifdef ZLE_SINGLE_ZERO_LITERAL_EN
        if (len == ONE) return '0;
`endif
        return run_tok(len);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eos   <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
        end else begin
            // Drain first; any load below overrides it so a new token replaces the delivered one.
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_eos) begin
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_eos   <= 1'b1;
                        end else if (in_zero) begin
                            if (MAX_RUN == ONE) begin
                                out_valid <= 1'b1;
                                out_data  <= run_tok(MAX_RUN);
                                out_eos   <= 1'b0;
                            end else begin
                                cnt   <= ONE;
                                state <= ZEROS;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= {1'b0, in_data};
                            out_eos   <= 1'b0;
                        end
                    end
                end
                ZEROS: begin
                    if (accept) begin
                        if (in_eos) begin
                            out_valid <= 1'b1;
                            out_data  <= term_tok(cnt);
                            out_eos   <= 1'b0;
                            state     <= PEND_EOS;
                        end else if (in_zero) begin
                            if (cnt + ONE == MAX_RUN) begin
                                out_valid <= 1'b1;
                                out_data  <= run_tok(MAX_RUN);
                                out_eos   <= 1'b0;
                                cnt       <= '0;
                                state     <= IDLE;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= term_tok(cnt);
                            out_eos   <= 1'b0;
                            hold      <= in_data;
                            state     <= PEND_LIT;
                        end
                    end
                end
                PEND_LIT: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= {1'b0, hold};
                        out_eos   <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                PEND_EOS: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_eos   <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zle_enc_param.sv
// Directed bench for zle_enc_param at W=8, CNT_W=4; expectations are hand-computed constants.
module tb_zle_enc_param;

    localparam int W     = 8;
    localparam int CNT_W = 4;

`ifdef ZLE_SINGLE_ZERO_LITERAL_EN
    localparam logic [W:0] ONE_RUN = 9'h000;
`else
    localparam logic [W:0] ONE_RUN = 9'h101;
`endif

    logic         clock;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_eos;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   out_data;
    logic         out_eos;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    zle_enc_param #(.W(W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_eos    (in_eos),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_eos   (out_eos),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one token, wait (bounded) for acceptance, return at accept edge + 1.
    task automatic push(input logic [W-1:0] d, input logic e);
        int n;
        in_data  = d;
        in_eos   = e;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $error("FAIL push_timeout observed=%0d expected=<20", n);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = '0;
        in_eos    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_data",  16'(out_data),  16'h000);
        chk("rst_out_eos",   16'(out_eos),   16'h0);
        chk("rst_in_ready",  16'(in_ready),  16'h1);
        @(negedge clock);
        reset = 1'b1;

        // Literals pass through, one cycle after accept
        push(8'h05, 1'b0);
        chk("lit5_valid", 16'(out_valid), 16'h1);
        chk("lit5_data",  16'(out_data),  16'h005);
        push(8'h07, 1'b0);
        chk("lit7_data",  16'(out_data),  16'h007);
        tick();
        chk("lit_drain",  16'(out_valid), 16'h0);

        // Three zeros then 0x09
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0);
        chk("z3_no_out",  16'(out_valid), 16'h0);
        push(8'h09, 1'b0);
        chk("run3_data",  16'(out_data),  16'h103);
        chk("run3_valid", 16'(out_valid), 16'h1);
        chk("pend_ready", 16'(in_ready),  16'h0);
        tick();
        chk("lit9_data",  16'(out_data),  16'h009);
        chk("lit9_ready", 16'(in_ready),  16'h1);
        tick();

        // Sixteen zeros then 0x04: max run emits on the 15th zero
        for (int i = 1; i <= 15; i++) begin
            push(8'h00, 1'b0);
            if (i == 14) chk("z14_no_out", 16'(out_valid), 16'h0);
        end
        chk("max_valid", 16'(out_valid), 16'h1);
        chk("max_data",  16'(out_data),  16'h10F);
        push(8'h00, 1'b0);
        chk("z16_no_out", 16'(out_valid), 16'h0);
        push(8'h04, 1'b0);
        chk("run1_data",  16'(out_data),  16'(ONE_RUN));
        tick();
        chk("lit4_data",  16'(out_data),  16'h004);
        tick();

        // Two zeros then end-of-stream
        push(8'h00, 1'b0); push(8'h00, 1'b0);
        push(8'hFF, 1'b1);
        chk("run2_data",  16'(out_data),  16'h102);
        chk("run2_eos",   16'(out_eos),   16'h0);
        chk("peos_ready", 16'(in_ready),  16'h0);
        tick();
        chk("eos_flag",   16'(out_eos),   16'h1);
        chk("eos_data",   16'(out_data),  16'h000);
        chk("eos_valid",  16'(out_valid), 16'h1);
        chk("eos_idle_rdy", 16'(in_ready), 16'h1);
        tick();
        chk("eos_drain",  16'(out_valid), 16'h0);

        // Backpressure: literal held stable for 5 cycles, extra token refused
        out_ready = 1'b0;
        push(8'h0A, 1'b0);
        in_data  = 8'h0B;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data",  16'(out_data),  16'h00A);
            chk("stall_valid", 16'(out_valid), 16'h1);
            chk("stall_ready", 16'(in_ready),  16'h0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("release_ready", 16'(in_ready), 16'h1);
        tick();
        chk("release_once", 16'(out_valid), 16'h0);

        // Reset while a run token is held and a literal is pending
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0);
        out_ready = 1'b0;
        push(8'h0D, 1'b0);
        chk("pre_rst_data", 16'(out_data), 16'h103);
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 16'(out_valid), 16'h0);
        chk("async_rst_data",  16'(out_data),  16'h000);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b1;
        push(8'h01, 1'b0);
        chk("post_rst_lit",  16'(out_data),  16'h001);
        tick();
        chk("post_rst_none", 16'(out_valid), 16'h0);

        // Reset during a partial run discards it
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0);
        reset = 1'b0;
        #1;
        chk("zrst_valid", 16'(out_valid), 16'h0);
        @(negedge clock);
        reset = 1'b1;
        push(8'h01, 1'b0);
        chk("zrst_lit", 16'(out_data), 16'h001);
        tick();
        chk("zrst_none", 16'(out_valid), 16'h0);

        // Single zero terminated by a nonzero word
        push(8'h00, 1'b0);
        push(8'h02, 1'b0);
        chk("single_valid", 16'(out_valid), 16'h1);
        chk("single_data",  16'(out_data),  16'(ONE_RUN));
        tick();
        chk("single_lit",   16'(out_data),  16'h002);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zle_enc_param.md
Name: zle_enc_param

Overview:
- Parametrised zero run-length encoder. Successor to the fixed 3-bit/4-bit ZLE datapath+FSM pair, merged into one block.
- Consumes a valid/ready token stream of W-bit words and emits (W+1)-bit tokens. Nonzero words pass through as literals. Runs of zeros collapse into one run token carrying the run length.
- Adds what the fixed version lacks: generic widths, backpressure, end-of-stream flush and a single-entry output register. Sits between a producer and the stream interconnect in the encoder pipeline.

Parameters:
- W, 8, input data width in bits (>= 2).
- CNT_W, 4, run counter width. Must satisfy 1 <= CNT_W <= W. MAX_RUN = 2^CNT_W - 1.

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- in_data  input  W  input word
- in_eos  input  1  token is end-of-stream; in_data is ignored
- in_valid  input  1  input token present
- in_ready  output  1  block accepts the input token this cycle
- out_data  output  W+1  bit W = 1: run token, length in low CNT_W bits (upper bits zero). Bit W = 0: literal word.
- out_eos  output  1  output token is end-of-stream; out_data = 0
- out_valid  output  1  output register holds a token
- out_ready  input  1  consumer takes the token this cycle

Behaviour:
- Reset values (asynchronous, active-low): out_valid = 0, out_data = 0, out_eos = 0, state = IDLE, cnt = 0, hold = 0.
- Reset mid-operation discards any partial run, held literal and undelivered token.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && state in {IDLE, ZEROS}. It is combinational and has no dependency on in_valid.
- out_valid/out_data/out_eos stay stable while out_valid && !out_ready.
- Latency: when an accepted token emits, the output appears on out_valid the next cycle. Full throughput of one token per cycle when out_ready is held high.
- State IDLE (no zeros pending):
  - accept nonzero x: load {0, x}, stay IDLE.
  - accept zero: cnt = 1, go ZEROS.
  - accept eos: load eos token, stay IDLE.
- State ZEROS (cnt zeros pending, 1 <= cnt < MAX_RUN):
  - accept zero with cnt + 1 < MAX_RUN: cnt = cnt + 1, no output.
  - accept zero with cnt + 1 == MAX_RUN: load run token {1, MAX_RUN}, cnt = 0, go IDLE.
  - accept nonzero x: load run token {1, cnt}, hold = x, go PEND_LIT.
  - accept eos: load run token {1, cnt}, go PEND_EOS.
- State PEND_LIT: in_ready = 0. When slot_free, load {0, hold}, cnt = 0, go IDLE.
- State PEND_EOS: in_ready = 0. When slot_free, load eos token, cnt = 0, go IDLE.
- A run token never carries length 0. A run of exactly MAX_RUN zeros emits immediately and does not wait for the next word.
- Simultaneous output transfer and new load in the same cycle: the new token replaces the old one and out_valid stays 1.
- Undefined state encodings recover to IDLE with cnt = 0.
- Counter arithmetic is CNT_W bits. Overflow is impossible because of the MAX_RUN rule.

Optional Feature:
- Macro: ZLE_SINGLE_ZERO_LITERAL_EN.
- Defined: a run ending with cnt == 1 (terminated by a nonzero word or eos) is emitted as literal {0, 0} instead of run token {1, 1}. PEND_LIT/PEND_EOS sequencing is unchanged.
- Undefined: every run, including length 1, is emitted as a run token.

Test Plan:
- Defaults (W = 8, CNT_W = 4), out_ready = 1, after reset: inputs 0x05, 0x07 -> out_data 0x005 then 0x007, each one cycle after accept; out_valid = 0 during reset.
- Inputs 0, 0, 0, 0x09 -> 0x103 then 0x009; in_ready = 0 for exactly one cycle (PEND_LIT).
- Sixteen zeros then 0x04 -> 0x10F on the 15th zero, then 0x101, then 0x004.
- Two zeros then eos -> 0x102, then out_eos = 1 with out_data = 0x000; block returns to IDLE.
- out_ready = 0 for 5 cycles with literal 0x0A loaded -> out_data 0x00A held stable, in_ready = 0; releasing out_ready delivers exactly one 0x00A.
- Three zeros accepted, then reset asserted -> out_valid = 0 immediately; after release, input 0x01 -> only 0x001 emitted, no run token. With ZLE_SINGLE_ZERO_LITERAL_EN defined, inputs 0, 0x02 -> 0x000 then 0x002.
